// File: rtl/alu_pkg.sv
// Opcode, FSM state and width definitions shared by the ALU arbiter slice.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] ADD  = 4'h1;
  localparam logic [3:0] SUB  = 4'h2;
  localparam logic [3:0] MUL  = 4'h4;
  localparam logic [3:0] DIV  = 4'h8;
  localparam logic [3:0] AND  = 4'hC;
  localparam logic [3:0] OR   = 4'hE;
  localparam logic [3:0] ADDN = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [3:0] ctrl);
    return ctrl inside {ADD, SUB, MUL, DIV, AND, OR, ADDN};
  endfunction

  function automatic logic [3:0] op_latency(input logic [3:0] ctrl, input logic [3:0] md_cycles);
    return ((ctrl == MUL) || (ctrl == DIV)) ? md_cycles : 4'd1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU-drive and response bundle between the ALU arbiter and its environment.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_ctrl;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_ctrl;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] alu_r0;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] rsp_r0;
  logic              rsp_ovf;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    input  alu_out, alu_r0, rsp_ready,
    output req0_ready, req1_ready,
    output alu_in1, alu_in2, alu_ctrl,
    output rsp_valid, rsp_id, rsp_data, rsp_r0, rsp_ovf, rsp_err
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    output alu_out, alu_r0, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_in1, alu_in2, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_data, rsp_r0, rsp_ovf, rsp_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input grant logic with a last-grant pointer.
// ALU_ARB_ROUND_ROBIN_EN selects round-robin; otherwise port 0 has fixed priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last_grant;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = r_last_grant ? 2'b01 : 2'b10;
  end
`else
  assign o_grant = {i_req[1] & ~i_req[0], i_req[0]};
`endif

  // Pointer is tracked in both builds; reset value favours port 0 first.
  always_ff @(posedge clk) begin
    if (rst) r_last_grant <= 1'b1;
    else     r_last_grant <= i_accept ? o_grant[1] : r_last_grant;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one op in flight, tagged responses.
// Build macro ALU_ARB_ROUND_ROBIN_EN: round-robin grant when defined, port 0 priority otherwise.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  // state | meaning
  // IDLE  | no op in flight; ready offered to the granted requester
  // EXEC  | ALU driven from registered operands; down-counter runs to op latency
  // RESP  | response held stable until rsp_ready

  localparam logic [3:0] MD_CYCLES = 4'(MULDIV_CYCLES);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [3:0]        r_op;
  logic [3:0]        r_alu_ctrl;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic [DATA_W-1:0] r_rsp_r0;
  logic              r_rsp_ovf;
  logic              r_rsp_err;

  logic              w_idle_en;
  logic              w_accept;
  logic [1:0]        w_grant;
  logic              w_sel;
  logic [3:0]        w_ctrl;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_trap;
  logic              w_ovf;
  logic              w_muldiv;

  assign w_idle_en = (r_state == ST_IDLE) && !rst;
  assign w_accept  = w_idle_en && (bus.req0_valid || bus.req1_valid);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    ({bus.req1_valid, bus.req0_valid}),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign bus.req0_ready = w_grant[0] && w_idle_en;
  assign bus.req1_ready = w_grant[1] && w_idle_en;

  assign w_sel  = w_grant[1];
  assign w_ctrl = w_sel ? bus.req1_ctrl : bus.req0_ctrl;
  assign w_a    = w_sel ? bus.req1_a    : bus.req0_a;
  assign w_b    = w_sel ? bus.req1_b    : bus.req0_b;
  assign w_trap = !is_legal(w_ctrl) || ((w_ctrl == DIV) && (w_b == '0));

  assign w_muldiv = (r_op == MUL) || (r_op == DIV);

  // Overflow is derived from operands and the ALU result; the ALU's own flag is not trusted.
  always_comb begin
    w_ovf = 1'b0;
    case (r_op)
      ADD, ADDN: w_ovf = (r_a[15] == r_b[15]) && (bus.alu_out[15] != r_a[15]);
      SUB:       w_ovf = (r_a[15] != r_b[15]) && (bus.alu_out[15] != r_a[15]);
      MUL:       w_ovf = bus.alu_r0 != {DATA_W{bus.alu_out[15]}};
      DIV:       w_ovf = (r_a == 16'h8000) && (r_b == 16'hFFFF);
      default:   w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_alu_ctrl  <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_r0    <= '0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rsp_id <= w_sel;
            if (w_trap) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_r0    <= '0;
              r_rsp_ovf   <= 1'b0;
            end else begin
              r_state    <= ST_EXEC;
              r_op       <= w_ctrl;
              r_a        <= w_a;
              r_b        <= w_b;
              r_alu_ctrl <= w_ctrl;
              r_cnt      <= op_latency(w_ctrl, MD_CYCLES) - 4'd1;
            end
          end
        end
        ST_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_RESP;
            r_alu_ctrl  <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bus.alu_out;
            r_rsp_r0    <= w_muldiv ? bus.alu_r0 : '0;
            r_rsp_ovf   <= w_ovf;
            r_rsp_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_in1   = r_a;
  assign bus.alu_in2   = r_b;
  assign bus.alu_ctrl  = r_alu_ctrl;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_r0    = r_rsp_r0;
  assign bus.rsp_ovf   = r_rsp_ovf;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int MD = 4;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter #(.MULDIV_CYCLES(MD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external ALU; r0 carries junk for non-mul/div ops.
  int alu_x, alu_y, alu_p;
  always_comb begin
    alu_x = int'($signed(bus.alu_in1));
    alu_y = int'($signed(bus.alu_in2));
    alu_p = 0;
    bus.alu_out = 16'h0;
    bus.alu_r0  = 16'h0;
    case (bus.alu_ctrl)
      4'h1, 4'hF: begin alu_p = alu_x + alu_y; bus.alu_out = alu_p[15:0]; bus.alu_r0 = 16'hA5A5; end
      4'h2: begin alu_p = alu_x - alu_y; bus.alu_out = alu_p[15:0]; bus.alu_r0 = 16'hA5A5; end
      4'h4: begin alu_p = alu_x * alu_y; bus.alu_out = alu_p[15:0]; bus.alu_r0 = alu_p[31:16]; end
      4'h8: begin
        if (alu_y != 0) begin
          alu_p = alu_x / alu_y;
          bus.alu_out = alu_p[15:0];
          alu_p = alu_x % alu_y;
          bus.alu_r0 = alu_p[15:0];
        end else begin
          bus.alu_out = 16'hDEAD;
        end
      end
      4'hC: begin bus.alu_out = bus.alu_in1 & bus.alu_in2; bus.alu_r0 = 16'h5A5A; end
      4'hE: begin bus.alu_out = bus.alu_in1 | bus.alu_in2; bus.alu_r0 = 16'h5A5A; end
      default: begin bus.alu_out = bus.alu_in1 ^ bus.alu_in2; bus.alu_r0 = 16'h5A5A; end
    endcase
  end

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic [15:0] r0;
    logic        ovf;
    logic        err;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          acc;
    int          rise;
  } exp_t;

  exp_t q[$];
  bit   ptr = 1'b1;
  int   idle_from = 0;

  // Reference: arithmetic on plain integers, then range checks for overflow.
  function automatic exp_t model(input logic id, input logic [3:0] c, input logic [15:0] a,
                                 input logic [15:0] b, input int acc);
    exp_t e;
    int x, y, r;
    logic [31:0] rv;
    x = int'($signed(a));
    y = int'($signed(b));
    e.id = id; e.op = c; e.a = a; e.b = b; e.acc = acc;
    e.data = 16'h0; e.r0 = 16'h0; e.ovf = 1'b0; e.err = 1'b0;
    r = 0;
    case (c)
      4'h1, 4'hF: r = x + y;
      4'h2:       r = x - y;
      4'h4:       r = x * y;
      4'h8:       r = (y == 0) ? 0 : x / y;
      4'hC:       r = int'($signed(a & b));
      4'hE:       r = int'($signed(a | b));
      default:    r = 0;
    endcase
    if (!(c inside {4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF}) || (c == 4'h8 && y == 0)) begin
      e.err  = 1'b1;
      e.rise = acc + 1;
    end else begin
      rv = r;
      e.data = rv[15:0];
      e.ovf  = (r > 32767) || (r < -32768);
      if (c == 4'h4) e.r0 = rv[31:16];
      if (c == 4'h8) begin rv = x % y; e.r0 = rv[15:0]; end
      e.rise = acc + (((c == 4'h4) || (c == 4'h8)) ? 1 + MD : 2);
    end
    return e;
  endfunction

  // Accept side: expected grant from the arbitration rule, push prediction on accept.
  bit         am_idle;
  logic [1:0] am_eg;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q.delete();
      ptr = 1'b1;
      idle_from = cyc + 1;
    end else begin
      am_idle = (q.size() == 0) && (cyc >= idle_from);
      am_eg = 2'b00;
      if (am_idle) begin
        if (bus.req0_valid && bus.req1_valid) am_eg = (RR && !ptr) ? 2'b10 : 2'b01;
        else am_eg = {bus.req1_valid, bus.req0_valid};
      end
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== am_eg) begin
        errors++;
        $display("FAIL grant cyc %0d: got ready=%b expected %b", cyc, {bus.req1_ready, bus.req0_ready}, am_eg);
      end
      if (am_eg == 2'b01) q.push_back(model(1'b0, bus.req0_ctrl, bus.req0_a, bus.req0_b, cyc));
      if (am_eg == 2'b10) q.push_back(model(1'b1, bus.req1_ctrl, bus.req1_a, bus.req1_b, cyc));
      if (am_eg != 2'b00) ptr = am_eg[1];
    end
  end

  // Response side: ALU drive window, rsp_valid timing, and response fields.
  bit          rm_ev, rm_win;
  logic [3:0]  rm_ctrl;
  logic [15:0] rm_in1, rm_in2;
  exp_t        rm_e;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      rm_win = (q.size() > 0) && (cyc > q[0].acc) && (cyc < q[0].rise);
      rm_ctrl = rm_win ? q[0].op : 4'h0;
      rm_in1  = rm_win ? q[0].a : 16'h0;
      rm_in2  = rm_win ? q[0].b : 16'h0;
      checks++;
      if (bus.alu_ctrl !== rm_ctrl || (rm_win && (bus.alu_in1 !== rm_in1 || bus.alu_in2 !== rm_in2))) begin
        errors++;
        $display("FAIL alu_drive cyc %0d: got ctrl=%h in1=%h in2=%h expected ctrl=%h in1=%h in2=%h",
                 cyc, bus.alu_ctrl, bus.alu_in1, bus.alu_in2, rm_ctrl, rm_in1, rm_in2);
      end
      rm_ev = (q.size() > 0) && (cyc >= q[0].rise);
      checks++;
      if (bus.rsp_valid !== rm_ev) begin
        errors++;
        $display("FAIL rsp_valid cyc %0d: got %b expected %b", cyc, bus.rsp_valid, rm_ev);
      end
      if (rm_ev) begin
        rm_e = q[0];
        checks++;
        if ({bus.rsp_id, bus.rsp_data, bus.rsp_r0, bus.rsp_ovf, bus.rsp_err} !==
            {rm_e.id, rm_e.data, rm_e.r0, rm_e.ovf, rm_e.err}) begin
          errors++;
          $display("FAIL rsp_fields cyc %0d: got id=%0d data=%h r0=%h ovf=%0d err=%0d expected id=%0d data=%h r0=%h ovf=%0d err=%0d",
                   cyc, bus.rsp_id, bus.rsp_data, bus.rsp_r0, bus.rsp_ovf, bus.rsp_err,
                   rm_e.id, rm_e.data, rm_e.r0, rm_e.ovf, rm_e.err);
        end
        if (bus.rsp_ready) begin
          q.delete(0);
          idle_from = cyc + 1;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.alu_in1, bus.alu_in2, bus.alu_ctrl, bus.rsp_valid,
         bus.rsp_id, bus.rsp_data, bus.rsp_r0, bus.rsp_ovf, bus.rsp_err} !== '0) begin
      errors++;
      $display("FAIL %s: outputs not all zero (alu_ctrl=%h in1=%h rsp_valid=%b data=%h r0=%h)",
               tag, bus.alu_ctrl, bus.alu_in1, bus.rsp_valid, bus.rsp_data, bus.rsp_r0);
    end
  endtask

  task automatic wait_idle(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      ok = (q.size() == 0) && (cyc >= idle_from);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", maxc);
    end
  endtask

  task automatic set_req(input bit port, input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    if (port) begin
      bus.req1_valid = 1'b1; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic issue(input bit port, input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(port, c, a, b);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = port ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready);
    end
    @(posedge clk); #1;
    if (port) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout port %0d: got no accept, expected one", port);
    end
  endtask

  function automatic logic [3:0] rnd_op();
    case ($urandom_range(0, 8))
      0: return 4'h1;
      1: return 4'h2;
      2: return 4'h4;
      3: return 4'h8;
      4: return 4'hC;
      5: return 4'hE;
      6: return 4'hF;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic rnd_req(input bit port);
    logic [15:0] a, b;
    int k;
    a = 16'($urandom);
    b = 16'($urandom);
    k = $urandom_range(0, 15);
    if (k == 0) b = 16'h0;
    if (k == 1) begin a = 16'h8000; b = 16'hFFFF; end
    if (k == 2) b = 16'hFFFF;
    set_req(port, rnd_op(), a, b);
    if ($urandom_range(0, 2) == 0) begin
      if (port) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    end
  endtask

  int acc_cnt;
  bit seen;

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_ctrl = 4'h0; bus.req0_a = 16'h0; bus.req0_b = 16'h0;
    bus.req1_valid = 1'b0; bus.req1_ctrl = 4'h0; bus.req1_a = 16'h0; bus.req1_b = 16'h0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset_outputs");

    issue(1'b0, 4'h1, 16'h7FFF, 16'h0001);
    wait_idle(20);

    // Both ports contend continuously for six accepts.
    @(posedge clk); #1;
    set_req(1'b0, 4'h1, 16'h0011, 16'h0022);
    set_req(1'b1, 4'h2, 16'h0100, 16'h0003);
    acc_cnt = 0;
    for (int i = 0; i < 60 && acc_cnt < 6; i++) begin
      @(negedge clk);
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) acc_cnt++;
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    checks++;
    if (acc_cnt != 6) begin
      errors++;
      $display("FAIL contend_accepts: got %0d expected 6", acc_cnt);
    end
    wait_idle(20);

    issue(1'b0, 4'h4, 16'h0100, 16'h0100);
    wait_idle(20);
    issue(1'b1, 4'h8, 16'h0007, 16'h0000);
    wait_idle(20);
    issue(1'b0, 4'h3, 16'h1234, 16'h5678);
    wait_idle(20);

    // Response back-pressure with a competing request waiting.
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    issue(1'b0, 4'h8, 16'hFFF9, 16'h0002);
    set_req(1'b1, 4'hE, 16'h00F0, 16'h0F00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL hold_rsp_timeout: got no rsp_valid, expected one");
    end
    repeat (5) @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.req1_valid && bus.req1_ready;
    end
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL post_hold_accept: got no accept, expected one");
    end
    wait_idle(20);

    // Reset while a divide is executing.
    issue(1'b0, 4'h8, 16'h0064, 16'h0003);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset_mid_exec");
    issue(1'b1, 4'h1, 16'h0005, 16'h0006);
    wait_idle(20);

    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      rnd_req(1'b0);
      rnd_req(1'b1);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` datapath between two requesters: the execute stage (port 0) and the address/immediate unit (port 1). It arbitrates requests, registers operands, and drives `alu` for a fixed number of cycles per opcode. It captures the result, remainder and computed overflow, traps divide-by-zero and illegal opcodes, and returns a tagged response over a valid/ready handshake. One operation is in flight at a time.

## Interface
- `MULDIV_CYCLES`, default 4: EXEC cycles for ctrl 4'h4/4'h8 (legal range 1–15); all other legal ops take 1.
- `clk  in  1  clock; all state updates on posedge`
- `rst  in  1  synchronous, active-high reset`
- `req0_valid / req1_valid  in  1  request present`
- `req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready`
- `req0_ctrl / req1_ctrl  in  4  ALU opcode`
- `req0_a, req0_b / req1_a, req1_b  in  16  signed operands`
- `alu_in1, alu_in2  out  16  operands to ALU`
- `alu_ctrl  out  4  opcode to ALU; 4'h0 whenever not in EXEC`
- `alu_out, alu_r0  in  16  ALU result / high word or remainder`
- `rsp_valid  out  1  response present`
- `rsp_ready  in  1  consumer accepts response`
- `rsp_id  out  1  requester index (0/1)`
- `rsp_data, rsp_r0  out  16  captured result / high word or remainder`
- `rsp_ovf  out  1  signed overflow`
- `rsp_err  out  1  divide-by-zero or illegal opcode`

## Operation
- Legal ctrl: 1 add, 2 sub, 4 mul, 8 div, C and, E or, F add. All other values are illegal.
- States:
  - IDLE: at most one `reqN_ready` high, to the granted valid requester. Neither is high if none is valid.
  - EXEC: drive `alu_*` from registered operands and count cycles.
  - RESP: hold response until `rsp_ready`.
- IDLE→EXEC on accept of a legal, non-trapping op.
- IDLE→RESP directly on accept of an illegal op or div with b==0. These set `rsp_err`=1 with data, r0 and ovf all 0, and `alu_ctrl` stays 4'h0.
- EXEC→RESP when the count reaches the op latency. Capture `alu_out`/`alu_r0` on that final cycle. `rsp_r0`=0 for ops other than mul/div.
- RESP→IDLE on `rsp_valid & rsp_ready`.
- Overflow is computed here; the ALU flag is not used.
  - add (1, F): operands have the same sign and the result sign differs.
  - sub: operand signs differ and the result sign differs from a.
  - mul: `alu_r0` is not all copies of `alu_out[15]`.
  - div: only −32768 / −1.
  - and/or: 0.
- Arbitration: round-robin with pointer `last_grant`. The requester other than `last_grant` wins when both are valid. The pointer updates to the winner on each accept.
- Request outputs (`reqN_ready`) depend only on state and the `reqN_valid` inputs, never on `rsp_ready`.

## Timing
- Reset:
  - State IDLE, `last_grant`=1 (port 0 favoured first).
  - All outputs 0, including `req*_ready`, `alu_*`, `rsp_*`.
- Reset mid-EXEC or mid-RESP abandons the op. No response is emitted and `rsp_valid` is 0 the next cycle.
- Accept at cycle N. Then `rsp_valid` rises at:
  - N+2 for single-cycle ops,
  - N+1+`MULDIV_CYCLES` for mul/div,
  - N+1 for trapped ops.
- Response outputs are stable while `rsp_valid`=1 and `rsp_ready`=0.
- Handshake at cycle M puts the block in IDLE at M+1. The earliest next accept is M+1, with no same-cycle bypass.
- Peak throughput is one op per 3 cycles.
- Operands are sampled only on accept. Request inputs are ignored otherwise.
- A requester dropping valid before accept is permitted and causes no accept.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined: round-robin as above.
- Undefined: fixed priority, port 0 always wins. `last_grant` is still maintained but unused.
- Timing and latency are identical either way.

## Structure
- Shared package `alu_pkg`: localparams for ctrl codes (ADD=4'h1, SUB=4'h2, MUL=4'h4, DIV=4'h8, AND=4'hC, OR=4'hE, ADDN=4'hF), state encoding IDLE/EXEC/RESP, and the 16-bit data width.
- Sub-module `rr_arb2`: two-input grant logic with pointer, covering both the `ALU_ARB_ROUND_ROBIN_EN` and fixed-priority behaviour.
- The ALU is instantiated outside this block.

## Test plan
- Port 0 add 0x7FFF + 0x0001 accepted at N → `alu_ctrl`=4'h1 at N+1; at N+2 `rsp_valid`=1, `rsp_id`=0, data 0x8000, ovf=1, err=0.
- Both ports valid every cycle, 6 single-cycle ops, `rsp_ready`=1 → grants alternate 0,1,0,1,0,1 with round-robin; all 0 with the macro undefined. Accepts are spaced 3 cycles apart.
- Mul 0x0100 × 0x0100, `MULDIV_CYCLES`=4, accepted at N → `rsp_valid` at N+5, data 0x0000, r0 0x0001, ovf=1.
- Div 7 / 0 and ctrl 4'h3 → `rsp_valid` at N+1, err=1, data 0; `alu_ctrl` never leaves 0.
- Div −7 / 2 with `rsp_ready` held low 5 cycles → data 0xFFFD, r0 0xFFFF, held stable; no new accept until one cycle after the handshake.
- `rst` asserted during EXEC of a div → next cycle all outputs 0, no response; a post-reset request on port 1 alone is accepted immediately.
